// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - ID/EX, MEM/WB and EX/MEM signal bundle for the execute stage
// Purpose: groups every non-clock/reset signal of ex_mem_stage.
// Ports (modport slave = execute stage, modport master = upstream/downstream driver):
//   ID/EX in  : mem_to_reg, reg_write_en, mem_read, mem_write, branch, alu_control[3:0],
//               alu_src, ID_EX_pc_in[63:0], read_data1/2[63:0], imm_gen[63:0],
//               ID_EX_rs1/rs2/rd[4:0]
//   MEM/WB in : MEM_WB_rd[4:0], MEM_WB_reg_write_en, MEM_WB_write_data[63:0]
//   EX/MEM out: mem_to_reg_out, reg_write_en_out, mem_read_out, mem_write_out,
//               alu_result[63:0], write_data[63:0], EX_MEM_rd_out[4:0],
//               pc_src_out, branch_target_out[63:0], flush_out
interface ex_mem_stage_if;
  logic        mem_to_reg;
  logic        reg_write_en;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [3:0]  alu_control;
  logic        alu_src;
  logic [63:0] ID_EX_pc_in;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] imm_gen;
  logic [4:0]  ID_EX_rs1;
  logic [4:0]  ID_EX_rs2;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_reg_write_en;
  logic [63:0] MEM_WB_write_data;

  logic        mem_to_reg_out;
  logic        reg_write_en_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [63:0] alu_result;
  logic [63:0] write_data;
  logic [4:0]  EX_MEM_rd_out;
  logic        pc_src_out;
  logic [63:0] branch_target_out;
  logic        flush_out;

  modport master (
    output mem_to_reg, reg_write_en, mem_read, mem_write, branch, alu_control, alu_src,
           ID_EX_pc_in, read_data1, read_data2, imm_gen, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           MEM_WB_rd, MEM_WB_reg_write_en, MEM_WB_write_data,
    input  mem_to_reg_out, reg_write_en_out, mem_read_out, mem_write_out, alu_result,
           write_data, EX_MEM_rd_out, pc_src_out, branch_target_out, flush_out
  );

  modport slave (
    input  mem_to_reg, reg_write_en, mem_read, mem_write, branch, alu_control, alu_src,
           ID_EX_pc_in, read_data1, read_data2, imm_gen, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           MEM_WB_rd, MEM_WB_reg_write_en, MEM_WB_write_data,
    output mem_to_reg_out, reg_write_en_out, mem_read_out, mem_write_out, alu_result,
           write_data, EX_MEM_rd_out, pc_src_out, branch_target_out, flush_out
  );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage (forwarding, ALU, BEQ resolve) plus EX/MEM register
// Purpose: takes ID/EX register outputs, forwards operands, computes the ALU result and
//   branch decision, and registers everything the memory stage and fetch need.
// Ports:
//   clk   - pipeline clock, all state on rising edge
//   reset - asynchronous, active-high, clears every output to 0
//   bus   - ex_mem_stage_if.slave (ID/EX and MEM/WB inputs, EX/MEM outputs)
// Configuration: define EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding;
//   without it the register-file operands are used as-is and MEM_WB_* are ignored.
module ex_mem_stage (
  input  logic           clk,
  input  logic           reset,
  ex_mem_stage_if.slave  bus
);

  logic        mem_to_reg_q;
  logic        reg_write_en_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [63:0] alu_result_q;
  logic [63:0] write_data_q;
  logic [4:0]  rd_q;
  logic        pc_src_q;
  logic [63:0] branch_target_q;

  logic [63:0] fwd_a;
  logic [63:0] fwd_b;
  logic [63:0] op_b;
  logic [63:0] alu_out;
  logic [63:0] cmp_diff;
  logic        branch_taken;

`ifdef EX_FORWARDING_EN
  // EX/MEM is checked first so the younger producer wins over MEM/WB.
  always_comb begin
    fwd_a = bus.read_data1;
    if (reg_write_en_q && (rd_q != 5'd0) && (rd_q == bus.ID_EX_rs1))
      fwd_a = alu_result_q;
    else if (bus.MEM_WB_reg_write_en && (bus.MEM_WB_rd != 5'd0) && (bus.MEM_WB_rd == bus.ID_EX_rs1))
      fwd_a = bus.MEM_WB_write_data;
  end

  always_comb begin
    fwd_b = bus.read_data2;
    if (reg_write_en_q && (rd_q != 5'd0) && (rd_q == bus.ID_EX_rs2))
      fwd_b = alu_result_q;
    else if (bus.MEM_WB_reg_write_en && (bus.MEM_WB_rd != 5'd0) && (bus.MEM_WB_rd == bus.ID_EX_rs2))
      fwd_b = bus.MEM_WB_write_data;
  end
`else
  assign fwd_a = bus.read_data1;
  assign fwd_b = bus.read_data2;

  // MEM/WB inputs stay on the bus for a uniform pipeline but have no effect here.
  logic unused_mem_wb;
  assign unused_mem_wb = ^{bus.MEM_WB_rd, bus.MEM_WB_reg_write_en, bus.MEM_WB_write_data};
`endif

  assign op_b = bus.alu_src ? bus.imm_gen : fwd_b;

  always_comb begin
    alu_out = 64'd0;
    case (bus.alu_control)
      4'b0000: alu_out = fwd_a & op_b;
      4'b0001: alu_out = fwd_a | op_b;
      4'b0010: alu_out = fwd_a + op_b;
      4'b0110: alu_out = fwd_a - op_b;
      4'b0011: alu_out = fwd_a ^ op_b;
      4'b0100: alu_out = fwd_a << op_b[5:0];
      4'b0101: alu_out = fwd_a >> op_b[5:0];
      4'b0111: alu_out = $unsigned($signed(fwd_a) >>> op_b[5:0]);
      default: alu_out = 64'd0;
    endcase
  end

  // BEQ compares the register operands, independent of alu_src.
  assign cmp_diff     = fwd_a - fwd_b;
  assign branch_taken = bus.branch && (cmp_diff == 64'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_to_reg_q    <= 1'b0;
      reg_write_en_q  <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      alu_result_q    <= 64'd0;
      write_data_q    <= 64'd0;
      rd_q            <= 5'd0;
      pc_src_q        <= 1'b0;
      branch_target_q <= 64'd0;
    end else begin
      alu_result_q    <= alu_out;
      write_data_q    <= fwd_b;
      branch_target_q <= bus.ID_EX_pc_in + (bus.imm_gen << 1);
      // A registered taken branch means the instruction now in EX is wrong-path:
      // turn it into a bubble so it cannot write, access memory or branch.
      if (pc_src_q) begin
        mem_to_reg_q   <= 1'b0;
        reg_write_en_q <= 1'b0;
        mem_read_q     <= 1'b0;
        mem_write_q    <= 1'b0;
        rd_q           <= 5'd0;
        pc_src_q       <= 1'b0;
      end else begin
        mem_to_reg_q   <= bus.mem_to_reg;
        reg_write_en_q <= bus.reg_write_en;
        mem_read_q     <= bus.mem_read;
        mem_write_q    <= bus.mem_write;
        rd_q           <= bus.ID_EX_rd;
        pc_src_q       <= branch_taken;
      end
    end
  end

  assign bus.mem_to_reg_out    = mem_to_reg_q;
  assign bus.reg_write_en_out  = reg_write_en_q;
  assign bus.mem_read_out      = mem_read_q;
  assign bus.mem_write_out     = mem_write_q;
  assign bus.alu_result        = alu_result_q;
  assign bus.write_data        = write_data_q;
  assign bus.EX_MEM_rd_out     = rd_q;
  assign bus.pc_src_out        = pc_src_q;
  assign bus.branch_target_out = branch_target_q;
  assign bus.flush_out         = pc_src_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic        m2r, rw, mr, mw, pcs, dc;
    logic [63:0] alu, wd, tgt;
    logic [4:0]  rd;
  } exp_t;

  exp_t m = '{default: '0};
  exp_t n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a + (~b + 64'd1);
      4'b0011: return a ^ b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return (a >> sh) | ({64{a[63]}} & ~({64{1'b1}} >> sh));
      default: return 64'd0;
    endcase
  endfunction

  // Value an instruction sees for source rs, given the older in-flight producers.
  function automatic logic [63:0] src_val(input logic [4:0] rs, input logic [63:0] rf,
                                          input exp_t prev, input logic wb_en,
                                          input logic [4:0] wb_rd, input logic [63:0] wb_data);
`ifdef EX_FORWARDING_EN
    if (prev.rw && prev.rd != 5'd0 && prev.rd == rs) return prev.alu;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs) return wb_data;
`endif
    return rf;
  endfunction

  // Behavioural model: what the EX/MEM register must hold after each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = '{default: '0};
    end else begin
      logic [63:0] a, b;
      a = src_val(bus.ID_EX_rs1, bus.read_data1, m, bus.MEM_WB_reg_write_en, bus.MEM_WB_rd, bus.MEM_WB_write_data);
      b = src_val(bus.ID_EX_rs2, bus.read_data2, m, bus.MEM_WB_reg_write_en, bus.MEM_WB_rd, bus.MEM_WB_write_data);
      n.alu = alu_ref(bus.alu_control, a, bus.alu_src ? bus.imm_gen : b);
      n.wd  = b;
      n.tgt = bus.ID_EX_pc_in + bus.imm_gen * 64'd2;
      n.dc  = m.pcs;
      if (m.pcs) begin
        {n.m2r, n.rw, n.mr, n.mw, n.pcs} = 5'b0;
        n.rd = 5'd0;
      end else begin
        n.m2r = bus.mem_to_reg;
        n.rw  = bus.reg_write_en;
        n.mr  = bus.mem_read;
        n.mw  = bus.mem_write;
        n.rd  = bus.ID_EX_rd;
        n.pcs = bus.branch && (a == b);
      end
      m = n;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_to_reg_out", 64'(bus.mem_to_reg_out), 64'(m.m2r));
      chk("reg_write_en_out", 64'(bus.reg_write_en_out), 64'(m.rw));
      chk("mem_read_out", 64'(bus.mem_read_out), 64'(m.mr));
      chk("mem_write_out", 64'(bus.mem_write_out), 64'(m.mw));
      chk("EX_MEM_rd_out", 64'(bus.EX_MEM_rd_out), 64'(m.rd));
      chk("pc_src_out", 64'(bus.pc_src_out), 64'(m.pcs));
      chk("flush_out", 64'(bus.flush_out), 64'(m.pcs));
      if (!m.dc) begin
        chk("alu_result", bus.alu_result, m.alu);
        chk("write_data", bus.write_data, m.wd);
        chk("branch_target_out", bus.branch_target_out, m.tgt);
      end
    end
  end

  // ctrl = {mem_to_reg, reg_write_en, mem_read, mem_write, branch}
  task automatic issue(input logic [3:0] op, input logic src, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [63:0] imm, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] ctrl,
                       input logic [63:0] pc);
    bus.alu_control = op;
    bus.alu_src     = src;
    bus.read_data1  = r1;
    bus.read_data2  = r2;
    bus.imm_gen     = imm;
    bus.ID_EX_rs1   = rs1;
    bus.ID_EX_rs2   = rs2;
    bus.ID_EX_rd    = rd;
    {bus.mem_to_reg, bus.reg_write_en, bus.mem_read, bus.mem_write, bus.branch} = ctrl;
    bus.ID_EX_pc_in = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [63:0] data);
    bus.MEM_WB_reg_write_en = en;
    bus.MEM_WB_rd           = rd;
    bus.MEM_WB_write_data   = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu"}, bus.alu_result, 64'd0);
    chk({tag, "_wd"}, bus.write_data, 64'd0);
    chk({tag, "_tgt"}, bus.branch_target_out, 64'd0);
    chk({tag, "_rd"}, 64'(bus.EX_MEM_rd_out), 64'd0);
    chk({tag, "_ctrl"}, 64'({bus.mem_to_reg_out, bus.reg_write_en_out, bus.mem_read_out,
                             bus.mem_write_out, bus.pc_src_out, bus.flush_out}), 64'd0);
  endtask

  localparam logic [4:0] C_RW = 5'b01000;
  localparam logic [4:0] C_MW = 5'b00010;
  localparam logic [4:0] C_BR = 5'b00001;

  logic [3:0]  ops  [7];
  logic [63:0] exps [7];
  bit fwd_on;

  initial begin
`ifdef EX_FORWARDING_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    ops  = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b1000};
    exps = '{64'h0, 64'h8000_0000_0000_0FF4, 64'h8000_0000_0000_0FF4,
             64'h0000_0000_0000_0F00, 64'h0800_0000_0000_000F,
             64'hF800_0000_0000_000F, 64'h0};

    issue(4'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 5'b0, 64'd0);
    wb(1'b0, 5'd0, 64'd0);
    step();
    check_zero("reset_init");
    reset = 1'b0;
    check_en = 1'b1;

    // ADD then SUB
    issue(4'b0010, 1'b0, 64'd5, 64'd3, 64'd0, 5'd10, 5'd11, 5'd2, C_RW, 64'd0);
    step();
    chk("add_dut", bus.alu_result, 64'd8);
    chk("add_model", m.alu, 64'd8);
    issue(4'b0110, 1'b0, 64'd3, 64'd5, 64'd0, 5'd12, 5'd13, 5'd3, C_RW, 64'd0);
    step();
    chk("sub_dut", bus.alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_model", m.alu, 64'hFFFF_FFFF_FFFF_FFFE);

    // Forwarding priority: EX/MEM holds 8 for x1, MEM/WB writes 99 to x1
    issue(4'b0010, 1'b0, 64'd5, 64'd3, 64'd0, 5'd14, 5'd15, 5'd1, C_RW, 64'd0);
    step();
    wb(1'b1, 5'd1, 64'd99);
    issue(4'b0010, 1'b1, 64'd0, 64'd0, 64'd1, 5'd1, 5'd16, 5'd5, C_RW, 64'd0);
    step();
    chk("fwd_prio_dut", bus.alu_result, fwd_on ? 64'd9 : 64'd1);
    chk("fwd_prio_model", m.alu, fwd_on ? 64'd9 : 64'd1);

    // Same with x0: never forwarded
    wb(1'b0, 5'd0, 64'd0);
    issue(4'b0010, 1'b0, 64'd5, 64'd3, 64'd0, 5'd14, 5'd15, 5'd0, C_RW, 64'd0);
    step();
    wb(1'b1, 5'd0, 64'd99);
    issue(4'b0010, 1'b1, 64'd0, 64'd0, 64'd1, 5'd0, 5'd16, 5'd5, C_RW, 64'd0);
    step();
    chk("x0_dut", bus.alu_result, 64'd1);

    // Store: rs2 forwarded from MEM/WB
    wb(1'b1, 5'd4, 64'hAB);
    issue(4'b0010, 1'b1, 64'd100, 64'd0, 64'd16, 5'd3, 5'd4, 5'd0, C_MW, 64'd0);
    step();
    chk("store_addr", bus.alu_result, 64'd116);
    chk("store_data", bus.write_data, fwd_on ? 64'hAB : 64'h0);
    chk("store_mw", 64'(bus.mem_write_out), 64'd1);

    // Taken branch, then squash of the next instruction
    wb(1'b0, 5'd0, 64'd0);
    issue(4'b0110, 1'b0, 64'd7, 64'd7, 64'd8, 5'd5, 5'd6, 5'd0, C_BR, 64'h100);
    step();
    chk("br_pc_src", 64'(bus.pc_src_out), 64'd1);
    chk("br_flush", 64'(bus.flush_out), 64'd1);
    chk("br_target", bus.branch_target_out, 64'h110);
    chk("br_target_model", m.tgt, 64'h110);
    issue(4'b0010, 1'b0, 64'd1, 64'd2, 64'd0, 5'd20, 5'd21, 5'd9, C_RW, 64'd0);
    step();
    chk("squash_rw", 64'(bus.reg_write_en_out), 64'd0);
    chk("squash_pc_src", 64'(bus.pc_src_out), 64'd0);
    chk("squash_rd", 64'(bus.EX_MEM_rd_out), 64'd0);

    // Not-taken branch
    issue(4'b0110, 1'b0, 64'd7, 64'd8, 64'd8, 5'd5, 5'd6, 5'd0, C_BR, 64'h200);
    step();
    chk("br_not_taken", 64'(bus.pc_src_out), 64'd0);

    // ALU table; b[5:0] = 4
    foreach (ops[i]) begin
      issue(ops[i], 1'b0, 64'h8000_0000_0000_00F0, 64'h0000_0000_0000_0F04, 64'd0,
            5'd22, 5'd23, 5'd0, 5'b0, 64'd0);
      step();
      chk($sformatf("alu_op_%b", ops[i]), bus.alu_result, exps[i]);
    end

    // Reset mid-operation with valid inputs held
    issue(4'b0010, 1'b0, 64'd5, 64'd3, 64'd4, 5'd10, 5'd11, 5'd2, C_RW | C_MW, 64'h40);
    step();
    chk("pre_reset_alu", bus.alu_result, 64'd8);
    #2;
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (2) step();
    check_zero("reset_hold");
    reset = 1'b0;
    step();
    chk("post_reset_alu", bus.alu_result, 64'd8);
    chk("post_reset_rd", 64'(bus.EX_MEM_rd_out), 64'd2);

    // Bubble passes through
    issue(4'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 5'b0, 64'd0);
    step();
    chk("bubble_ctrl", 64'({bus.mem_to_reg_out, bus.reg_write_en_out, bus.mem_read_out,
                            bus.mem_write_out, bus.pc_src_out}), 64'd0);
    step();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
